// File: rtl/frame_buffer_sequencer.sv
// Triple-buffer manager: rotates display / pending / write roles among three DDR
// frame buffers and issues toggle-style blank requests to the downstream blanker.
module frame_buffer_sequencer #(
  parameter int unsigned                  FRAME_ADDR_LENGTH = 8,
  parameter logic [FRAME_ADDR_LENGTH-1:0] BASE_ADDR         = 8'h70,
  parameter logic [FRAME_ADDR_LENGTH-1:0] ADDR_STEP         = 8'h04,
  parameter logic [23:0]                  BLANK_TIMEOUT     = 24'd4000000
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         blank_enable_i,
  input  logic                         vsync_i,
  input  logic                         frame_done_i,
  input  logic                         blank_done_i,
  output logic                         frame_swap_o,
  output logic [FRAME_ADDR_LENGTH-1:0] blank_addr_o,
  output logic [FRAME_ADDR_LENGTH-1:0] write_addr_o,
  output logic [FRAME_ADDR_LENGTH-1:0] read_addr_o,
  output logic                         write_ready_o,
  output logic [15:0]                  dropped_cnt_o,
  output logic [1:0]                   status_o
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_READY,
    ST_BLANKING
  } state_t;

  state_t      state;
  logic [1:0]  r_idx, p_idx, w_idx;
  logic        p_valid;
  logic [23:0] blank_cnt;

  logic        rotate, request, show_pending;
  logic [1:0]  rot_p, rot_w, nxt_r, nxt_p;
  logic        rot_valid, nxt_valid;

  function automatic logic [FRAME_ADDR_LENGTH-1:0] buf_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    buf_addr = BASE_ADDR;
      2'd1:    buf_addr = BASE_ADDR + ADDR_STEP;
      default: buf_addr = BASE_ADDR + ADDR_STEP + ADDR_STEP;
    endcase
  endfunction

  // A same-cycle vsync sees the pending buffer produced by this cycle's rotation.
  always_comb begin
    rotate       = (state == ST_READY) && frame_done_i;
    request      = rotate || (state == ST_INIT);
    rot_p        = rotate ? w_idx : p_idx;
    rot_w        = rotate ? p_idx : w_idx;
    rot_valid    = rotate || p_valid;
    show_pending = vsync_i && rot_valid;
    nxt_r        = show_pending ? rot_p : r_idx;
    nxt_p        = show_pending ? r_idx : rot_p;
    nxt_valid    = rot_valid && !vsync_i;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_INIT;
      r_idx         <= 2'd0;
      w_idx         <= 2'd1;
      p_idx         <= 2'd2;
      p_valid       <= 1'b0;
      blank_cnt     <= '0;
      frame_swap_o  <= 1'b0;
      write_ready_o <= 1'b0;
      dropped_cnt_o <= '0;
      status_o      <= '0;
      read_addr_o   <= BASE_ADDR;
      write_addr_o  <= BASE_ADDR + ADDR_STEP;
      blank_addr_o  <= BASE_ADDR + ADDR_STEP;
    end else begin
      r_idx         <= nxt_r;
      p_idx         <= nxt_p;
      w_idx         <= rot_w;
      p_valid       <= nxt_valid;
      read_addr_o   <= buf_addr(nxt_r);
      write_ready_o <= (state == ST_READY) && !request;

      if (rotate && p_valid && (dropped_cnt_o != 16'hFFFF))
        dropped_cnt_o <= dropped_cnt_o + 16'd1;
      if (frame_done_i && (state != ST_READY))
        status_o[1] <= 1'b1;

      if (request) begin
        write_addr_o <= buf_addr(rot_w);
        blank_addr_o <= buf_addr(rot_w);
        if (blank_enable_i) begin
          frame_swap_o <= ~frame_swap_o;
          blank_cnt    <= '0;
          state        <= ST_BLANKING;
        end else begin
          state <= ST_READY;
        end
      end else if (state == ST_BLANKING) begin
        if (blank_done_i) begin
          state <= ST_READY;
        end else if (blank_cnt == BLANK_TIMEOUT - 24'd1) begin
          state       <= ST_READY;
          status_o[0] <= 1'b1;
        end else begin
          blank_cnt <= blank_cnt + 24'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_sequencer.sv
// Bench for frame_buffer_sequencer: directed vector table, hand-written corner
// sequences, then randomized traffic against a role-based reference model.
module tb_frame_buffer_sequencer;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic        swap;
    logic        rdy;
    logic [7:0]  waddr;
    logic [7:0]  baddr;
    logic [7:0]  raddr;
    logic [15:0] drop;
    logic [1:0]  status;
  } outs_t;

  typedef struct packed {
    logic  en;
    logic  vs;
    logic  fd;
    logic  bd;
    outs_t exp;
  } vec_t;

  logic        aclk;
  logic        aresetn;
  logic        blank_enable_i, vsync_i, frame_done_i, blank_done_i;
  logic        frame_swap_o, write_ready_o;
  logic [7:0]  blank_addr_o, write_addr_o, read_addr_o;
  logic [15:0] dropped_cnt_o;
  logic [1:0]  status_o;

  int vectors     = 0;
  int miscompares = 0;

  frame_buffer_sequencer #(
    .FRAME_ADDR_LENGTH(8),
    .BASE_ADDR        (8'h70),
    .ADDR_STEP        (8'h04),
    .BLANK_TIMEOUT    (24'd16)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .blank_enable_i(blank_enable_i),
    .vsync_i       (vsync_i),
    .frame_done_i  (frame_done_i),
    .blank_done_i  (blank_done_i),
    .frame_swap_o  (frame_swap_o),
    .blank_addr_o  (blank_addr_o),
    .write_addr_o  (write_addr_o),
    .read_addr_o   (read_addr_o),
    .write_ready_o (write_ready_o),
    .dropped_cnt_o (dropped_cnt_o),
    .status_o      (status_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Reference model: which physical buffer holds each role (0 display, 1 pending, 2 write).
  int    role_buf[3];
  bit    pend;
  int    mode;
  longint cyc;
  longint blank_start;
  outs_t m;

  function automatic logic [7:0] addr_of(input int b);
    return 8'(112 + 4 * b);
  endfunction

  function automatic outs_t reset_outs();
    outs_t o;
    o = '{swap: 1'b0, rdy: 1'b0, waddr: 8'h74, baddr: 8'h74, raddr: 8'h70,
          drop: 16'd0, status: 2'd0};
    return o;
  endfunction

  task automatic model_reset();
    role_buf[0] = 0;
    role_buf[1] = 2;
    role_buf[2] = 1;
    pend = 0;
    mode = 0;
    cyc  = 0;
    blank_start = 0;
    m = reset_outs();
  endtask

  task automatic model_step(input logic en, input logic vs, input logic fd, input logic bd);
    bit req;
    bit was_ready;
    int t;
    cyc++;
    req = 0;
    was_ready = (mode == 1);
    m.rdy = 1'b0;
    if (mode == 0) begin
      req = 1;
      if (fd) m.status[1] = 1'b1;
    end else if (mode == 1) begin
      if (fd) begin
        if (pend && m.drop != 16'hFFFF) m.drop = m.drop + 16'd1;
        t = role_buf[1]; role_buf[1] = role_buf[2]; role_buf[2] = t;
        pend = 1;
        req = 1;
      end
    end else begin
      if (fd) m.status[1] = 1'b1;
      if (bd) mode = 1;
      else if (cyc - blank_start >= TIMEOUT) begin
        mode = 1;
        m.status[0] = 1'b1;
      end
    end
    if (was_ready && !req) m.rdy = 1'b1;
    if (req) begin
      m.waddr = addr_of(role_buf[2]);
      m.baddr = addr_of(role_buf[2]);
      if (en) begin
        m.swap = ~m.swap;
        mode = 2;
        blank_start = cyc;
      end else begin
        mode = 1;
      end
    end
    if (vs && pend) begin
      t = role_buf[0]; role_buf[0] = role_buf[1]; role_buf[1] = t;
      pend = 0;
    end
    m.raddr = addr_of(role_buf[0]);
  endtask

  task automatic applyStimulus(input logic en, input logic vs, input logic fd, input logic bd);
    blank_enable_i = en;
    vsync_i        = vs;
    frame_done_i   = fd;
    blank_done_i   = bd;
    model_step(en, vs, fd, bd);
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    bit bad;
    act = '{swap: frame_swap_o, rdy: write_ready_o, waddr: write_addr_o,
            baddr: blank_addr_o, raddr: read_addr_o, drop: dropped_cnt_o,
            status: status_o};
    vectors++;
    bad = 0;
    if (act.swap !== exp.swap) begin
      $display("[TB] FAIL %s: frame_swap got %b expected %b", name, act.swap, exp.swap); bad = 1;
    end
    if (act.rdy !== exp.rdy) begin
      $display("[TB] FAIL %s: write_ready got %b expected %b", name, act.rdy, exp.rdy); bad = 1;
    end
    if (act.waddr !== exp.waddr) begin
      $display("[TB] FAIL %s: write_addr got %h expected %h", name, act.waddr, exp.waddr); bad = 1;
    end
    if (act.baddr !== exp.baddr) begin
      $display("[TB] FAIL %s: blank_addr got %h expected %h", name, act.baddr, exp.baddr); bad = 1;
    end
    if (act.raddr !== exp.raddr) begin
      $display("[TB] FAIL %s: read_addr got %h expected %h", name, act.raddr, exp.raddr); bad = 1;
    end
    if (act.drop !== exp.drop) begin
      $display("[TB] FAIL %s: dropped_cnt got %0d expected %0d", name, act.drop, exp.drop); bad = 1;
    end
    if (act.status !== exp.status) begin
      $display("[TB] FAIL %s: status got %b expected %b", name, act.status, exp.status); bad = 1;
    end
    if (bad) miscompares++;
  endtask

  task automatic doReset();
    @(negedge aclk);
    aresetn        = 1'b0;
    blank_enable_i = 1'b0;
    vsync_i        = 1'b0;
    frame_done_i   = 1'b0;
    blank_done_i   = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("reset_state", reset_outs());
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  function automatic vec_t mk(input logic en, input logic vs, input logic fd, input logic bd,
                              input logic sw, input logic rdy, input logic [7:0] wa,
                              input logic [7:0] ra, input logic [15:0] dr, input logic [1:0] st);
    vec_t v;
    v.en = en; v.vs = vs; v.fd = fd; v.bd = bd;
    v.exp = '{swap: sw, rdy: rdy, waddr: wa, baddr: wa, raddr: ra, drop: dr, status: st};
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    outs_t e;
    logic en, vs, fd, bd;

    aresetn        = 1'b0;
    blank_enable_i = 1'b0;
    vsync_i        = 1'b0;
    frame_done_i   = 1'b0;
    blank_done_i   = 1'b0;

    //             en vs fd bd  sw rdy waddr  raddr  drop st
    tbl[0]  = mk(1, 0, 0, 0,  1, 0, 8'h74, 8'h70, 0, 2'd0);
    tbl[1]  = mk(1, 0, 0, 1,  1, 0, 8'h74, 8'h70, 0, 2'd0);
    tbl[2]  = mk(1, 0, 0, 0,  1, 1, 8'h74, 8'h70, 0, 2'd0);
    tbl[3]  = mk(1, 0, 1, 0,  0, 0, 8'h78, 8'h70, 0, 2'd0);
    tbl[4]  = mk(1, 1, 0, 0,  0, 0, 8'h78, 8'h74, 0, 2'd0);
    tbl[5]  = mk(1, 0, 0, 1,  0, 0, 8'h78, 8'h74, 0, 2'd0);
    tbl[6]  = mk(1, 0, 0, 0,  0, 1, 8'h78, 8'h74, 0, 2'd0);
    tbl[7]  = mk(1, 0, 1, 0,  1, 0, 8'h70, 8'h74, 0, 2'd0);
    tbl[8]  = mk(1, 0, 0, 1,  1, 0, 8'h70, 8'h74, 0, 2'd0);
    tbl[9]  = mk(1, 0, 0, 0,  1, 1, 8'h70, 8'h74, 0, 2'd0);
    tbl[10] = mk(1, 0, 1, 0,  0, 0, 8'h78, 8'h74, 1, 2'd0);
    tbl[11] = mk(1, 0, 1, 0,  0, 0, 8'h78, 8'h74, 1, 2'd2);
    tbl[12] = mk(1, 0, 0, 1,  0, 0, 8'h78, 8'h74, 1, 2'd2);
    tbl[13] = mk(1, 0, 0, 0,  0, 1, 8'h78, 8'h74, 1, 2'd2);
    tbl[14] = mk(1, 1, 0, 0,  0, 1, 8'h78, 8'h70, 1, 2'd2);
    tbl[15] = mk(0, 0, 1, 0,  0, 0, 8'h74, 8'h70, 1, 2'd2);
    tbl[16] = mk(0, 0, 0, 0,  0, 1, 8'h74, 8'h70, 1, 2'd2);
    tbl[17] = mk(0, 1, 1, 0,  0, 0, 8'h78, 8'h74, 2, 2'd2);
    tbl[18] = mk(0, 0, 0, 0,  0, 1, 8'h78, 8'h74, 2, 2'd2);

    doReset();
    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i].en, tbl[i].vs, tbl[i].fd, tbl[i].bd);
      checkOutput($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Blanking disabled, then frame_done and vsync together straight out of reset.
    doReset();
    e = reset_outs();
    applyStimulus(0, 0, 0, 0);
    checkOutput("noblank_init", e);
    applyStimulus(0, 0, 0, 0);
    e.rdy = 1'b1;
    checkOutput("noblank_ready", e);
    applyStimulus(0, 1, 1, 0);
    e.rdy = 1'b0; e.waddr = 8'h78; e.baddr = 8'h78; e.raddr = 8'h74;
    checkOutput("fd_vsync_same_cycle", e);
    applyStimulus(0, 1, 0, 0);
    e.rdy = 1'b1;
    checkOutput("vsync_no_pending", e);

    // Blank timeout: write_ready rises 17 cycles after the toggle.
    doReset();
    e = reset_outs();
    applyStimulus(1, 0, 0, 0);
    e.swap = 1'b1;
    checkOutput("timeout_toggle", e);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      applyStimulus(1, 0, 0, 0);
      e.rdy       = (k >= TIMEOUT + 1);
      e.status[0] = (k >= TIMEOUT);
      checkOutput($sformatf("timeout_wait[%0d]", k), e);
    end

    // Reset asserted mid-blank takes effect without a clock edge.
    doReset();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("async_reset_midblank", reset_outs());

    // Randomized traffic against the reference model.
    doReset();
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      vs = ($urandom_range(0, 5) == 0);
      fd = ($urandom_range(0, 3) == 0);
      bd = ($urandom_range(0, 6) == 0);
      applyStimulus(en, vs, fd, bd);
      checkOutput($sformatf("random[%0d]", i), m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
